downsample_ctrl: RTL and testbench
==================================

# downsample_ctrl

Sequencer for the flexible-downsampling layer. It walks every output pixel of the HOUT×HOUT map in raster order and computes fixed-point source coordinates by stride accumulation, with no multipliers. For each pixel it fetches the four bilinear neighbours from the ifmap buffer over a 1-cycle-latency read port. It then hands the neighbours and fractional weights to the bilinear interpolation unit over a valid/ready stream.

## Interface
Parameters:
- HIN, 27: input map side length.
- HOUT, 19: output map side length.
- FRAC_W, 8: fractional bits of the stride and of the position accumulators.
- STRIDE_Q, 370: stride in unsigned fixed point with FRAC_W fractional bits; 370 ≈ 1.4453.
- ADDR_W, $clog2(HIN*HIN): ifmap address width.
- OADDR_W, $clog2(HOUT*HOUT): ofmap address width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- rd_en  out  1  ifmap read strobe.
- rd_addr  out  ADDR_W  ifmap address, row*HIN+col.
- rd_data  in  8  ifmap data, valid the cycle after rd_en.
- out_valid  out  1  pixel bundle valid.
- out_ready  in  1  interpolator accepts the bundle.
- out_addr  out  OADDR_W  ofmap address, i*HOUT+j.
- out_fx, out_fy  out  FRAC_W  column and row fractional offsets.
- out_a1, out_a2, out_a3, out_a4  out  8 each  neighbours: a1 (ceil_r, ceil_c), a2 (ceil_r, floor_c), a3 (floor_r, ceil_c), a4 (floor_r, floor_c).

## Operation
- Accumulators py, px are wide enough for (HOUT-1)*STRIDE_Q. Both clear at start.
- Per pixel:
  - floor = pos >> FRAC_W.
  - frac = pos[FRAC_W-1:0].
  - ceil = floor + (frac != 0), then clamped to HIN-1.
- Step rules:
  - After each accepted bundle, px += STRIDE_Q and j += 1.
  - At j == HOUT-1: j = 0, px = 0, py += STRIDE_Q, i += 1.
- FSM states: IDLE, RD0, RD1, RD2, RD3, CAP, EMIT, DONE.
- IDLE: start → RD0. A start arriving while not in IDLE is dropped.
- RD0: issues the a4 read address.
- RD1: issues a3 and captures a4.
- RD2: issues a2 and captures a3.
- RD3: issues a1 and captures a2.
- CAP: captures a1; → EMIT.
- EMIT: out_valid held high with all bundle fields stable until out_ready.
  - On handshake, if the pixel is the last one (i == j == HOUT-1) → DONE; else step and → RD0.
- DONE: done = 1 for exactly one cycle; → IDLE.
- The four reads are always issued, even when frac == 0 and ceil == floor.

## Timing
- Reset: state IDLE; busy, done, rd_en, out_valid = 0; rd_addr, out_addr, out_fx, out_fy, out_a* = 0; counters and accumulators = 0.
- Reset asserted mid-frame takes priority over all other inputs. It aborts the frame with no done pulse; the next start restarts at pixel 0.
- rd_en is high only in RD0 through RD3. rd_data is sampled exactly one cycle after each rd_en.
- Minimum cost per pixel is 6 cycles with out_ready tied high.
- A frame with ready tied high takes 6*HOUT² cycles from start acceptance to the done cycle inclusive of the last handshake, plus 1.
- Backpressure only stalls EMIT. No reads are issued while stalled.
- out_ready asserted outside EMIT has no effect.

## Test plan
- Reset check: rst held 3 cycles mid-frame → all outputs 0, state IDLE, no done pulse. A subsequent start restarts at out_addr 0.
- Coordinates, ramp ifmap (ifmap[r][c] = r*HIN+c, mod 256):
  - Pixel (0,0) → fx = fy = 0; a1 = a2 = a3 = a4 = 0.
  - Pixel (0,1) → fx = 114, fy = 0; a4 = 1, a3 = 2, a2 = 1, a1 = 2.
  - Pixel (1,2) → fx = 228, fy = 114.
  - rd_addr sequence for pixel (1,2): 29, 30, 56, 57.
- Boundary clamp: pixel (18,18) → pos = 6660, floor = 26, frac = 4, ceil clamped to 26. All four rd_addr = 728; out_addr = 360.
- Throughput: out_ready tied high → 361 handshakes, done asserts exactly once, busy falls with done.
- Backpressure: out_ready low for 10 cycles on pixel 5 → bundle stable, no rd_en, out_addr 5 not skipped or repeated.
- Spurious start while busy → ignored; frame completes normally with a single done pulse.

Source files
------------

// File: rtl/downsample_ctrl.sv
// downsample_ctrl: raster-order sequencer for the flexible-downsampling layer.
// Walks every pixel of the HOUT x HOUT output map, derives fixed-point source
// coordinates by accumulating the stride, reads the four bilinear neighbours
// from the ifmap buffer (1-cycle read latency) and presents them, together
// with the fractional weights, to the interpolator on a valid/ready stream.
module downsample_ctrl #(
   parameter int HIN      = 27,
   parameter int HOUT     = 19,
   parameter int FRAC_W   = 8,
   parameter int STRIDE_Q = 370,
   parameter int ADDR_W   = $clog2(HIN*HIN),
   parameter int OADDR_W  = $clog2(HOUT*HOUT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [7:0]         rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OADDR_W-1:0] out_addr,
   output logic [FRAC_W-1:0]  out_fx,
   output logic [FRAC_W-1:0]  out_fy,
   output logic [7:0]         out_a1,
   output logic [7:0]         out_a2,
   output logic [7:0]         out_a3,
   output logic [7:0]         out_a4
);

   // Position accumulators must hold (HOUT-1)*STRIDE_Q and always carry at
   // least one integer bit above the fraction.
   localparam int POS_RAW = $clog2((HOUT-1)*STRIDE_Q + 1);
   localparam int POS_W   = (POS_RAW > FRAC_W) ? POS_RAW : FRAC_W + 1;
   localparam int CNT_W   = (HOUT > 1) ? $clog2(HOUT) : 1;

   localparam logic [ADDR_W-1:0] MAX_IDX  = ADDR_W'(HIN - 1);
   localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(HIN);
   localparam logic [POS_W-1:0]  STEP     = POS_W'(STRIDE_Q);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(HOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      RD2,
      RD3,
      CAP,
      EMIT,
      DONE
   } state_t;

   state_t               state_q,     state_d;
   logic [CNT_W-1:0]     i_q,         i_d;
   logic [CNT_W-1:0]     j_q,         j_d;
   logic [POS_W-1:0]     px_q,        px_d;
   logic [POS_W-1:0]     py_q,        py_d;
   logic [OADDR_W-1:0]   oaddr_q,     oaddr_d;
   logic                 busy_q,      busy_d;
   logic                 done_q,      done_d;
   logic                 rd_en_q,     rd_en_d;
   logic [ADDR_W-1:0]    rd_addr_q,   rd_addr_d;
   logic                 out_valid_q, out_valid_d;
   logic [OADDR_W-1:0]   out_addr_q,  out_addr_d;
   logic [FRAC_W-1:0]    out_fx_q,    out_fx_d;
   logic [FRAC_W-1:0]    out_fy_q,    out_fy_d;
   logic [7:0]           out_a1_q,    out_a1_d;
   logic [7:0]           out_a2_q,    out_a2_d;
   logic [7:0]           out_a3_q,    out_a3_d;
   logic [7:0]           out_a4_q,    out_a4_d;

   logic [ADDR_W-1:0]    row_lo, row_hi, col_lo, col_hi;
   logic [FRAC_W-1:0]    frac_x, frac_y;
   logic                 last_pix;

   // Ceil of a fixed-point position: bump the floor when any fraction remains,
   // then pin it to the last valid row/column of the ifmap.
   function automatic logic [ADDR_W-1:0] ceil_idx(input logic [ADDR_W-1:0] fl,
                                                  input logic [FRAC_W-1:0] fr);
      logic [ADDR_W-1:0] c;
      c = (fr != '0) ? fl + ADDR_W'(1) : fl;
      if (c > MAX_IDX) begin
         c = MAX_IDX;
      end
      return c;
   endfunction

   // Linear ifmap address of (row, col); HIN is a constant so this is shift-add.
   function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] r,
                                                  input logic [ADDR_W-1:0] c);
      return r * ROW_LEN + c;
   endfunction

   assign last_pix = (i_q == LAST_IDX) && (j_q == LAST_IDX);

   // Sequencer: state transitions, raster stepping and neighbour capture.
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      px_d       = px_q;
      py_d       = py_q;
      oaddr_d    = oaddr_q;
      out_addr_d = out_addr_q;
      out_fx_d   = out_fx_q;
      out_fy_d   = out_fy_q;
      out_a1_d   = out_a1_q;
      out_a2_d   = out_a2_q;
      out_a3_d   = out_a3_q;
      out_a4_d   = out_a4_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RD0;
               i_d     = '0;
               j_d     = '0;
               px_d    = '0;
               py_d    = '0;
               oaddr_d = '0;
            end
         end
         RD0: begin
            state_d = RD1;
         end
         RD1: begin
            state_d  = RD2;
            out_a4_d = rd_data;
         end
         RD2: begin
            state_d  = RD3;
            out_a3_d = rd_data;
         end
         RD3: begin
            state_d  = CAP;
            out_a2_d = rd_data;
         end
         CAP: begin
            state_d    = EMIT;
            out_a1_d   = rd_data;
            out_fx_d   = px_q[FRAC_W-1:0];
            out_fy_d   = py_q[FRAC_W-1:0];
            out_addr_d = oaddr_q;
         end
         EMIT: begin
            if (out_ready) begin
               if (last_pix) begin
                  state_d = DONE;
               end else begin
                  state_d = RD0;
                  oaddr_d = oaddr_q + OADDR_W'(1);
                  if (j_q == LAST_IDX) begin
                     j_d  = '0;
                     px_d = '0;
                     i_d  = i_q + CNT_W'(1);
                     py_d = py_q + STEP;
                  end else begin
                     j_d  = j_q + CNT_W'(1);
                     px_d = px_q + STEP;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next-cycle outputs: neighbour addresses come from the upcoming position so
   // the first read of a pixel is already correct in the cycle RD0 is entered.
   always_comb begin
      row_lo = ADDR_W'(py_d >> FRAC_W);
      col_lo = ADDR_W'(px_d >> FRAC_W);
      frac_y = py_d[FRAC_W-1:0];
      frac_x = px_d[FRAC_W-1:0];
      row_hi = ceil_idx(row_lo, frac_y);
      col_hi = ceil_idx(col_lo, frac_x);
      rd_addr_d = '0;
      case (state_d)
         RD0:     rd_addr_d = map_addr(row_lo, col_lo);
         RD1:     rd_addr_d = map_addr(row_lo, col_hi);
         RD2:     rd_addr_d = map_addr(row_hi, col_lo);
         RD3:     rd_addr_d = map_addr(row_hi, col_hi);
         default: rd_addr_d = '0;
      endcase
      rd_en_d     = state_d inside {RD0, RD1, RD2, RD3};
      busy_d      = state_d inside {RD0, RD1, RD2, RD3, CAP, EMIT};
      done_d      = (state_d == DONE);
      out_valid_d = (state_d == EMIT);
   end

   // State and output registers; reset clears everything and wins over start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         i_q         <= '0;
         j_q         <= '0;
         px_q        <= '0;
         py_q        <= '0;
         oaddr_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_fx_q    <= '0;
         out_fy_q    <= '0;
         out_a1_q    <= '0;
         out_a2_q    <= '0;
         out_a3_q    <= '0;
         out_a4_q    <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         px_q        <= px_d;
         py_q        <= py_d;
         oaddr_q     <= oaddr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_fx_q    <= out_fx_d;
         out_fy_q    <= out_fy_d;
         out_a1_q    <= out_a1_d;
         out_a2_q    <= out_a2_d;
         out_a3_q    <= out_a3_d;
         out_a4_q    <= out_a4_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_fx    = out_fx_q;
   assign out_fy    = out_fy_q;
   assign out_a1    = out_a1_q;
   assign out_a2    = out_a2_q;
   assign out_a3    = out_a3_q;
   assign out_a4    = out_a4_q;

endmodule

// File: tb/tb_downsample_ctrl.sv
// tb_downsample_ctrl: directed bench for the downsampling sequencer, backed by
// a ramp ifmap (value = address mod 256) and an arithmetic pixel model.
module tb_downsample_ctrl;

   localparam int HIN      = 27;
   localparam int HOUT     = 19;
   localparam int FRAC_W   = 8;
   localparam int STRIDE_Q = 370;
   localparam int ADDR_W   = $clog2(HIN*HIN);
   localparam int OADDR_W  = $clog2(HOUT*HOUT);
   localparam int NPIX     = HOUT*HOUT;

   logic               clk       = 1'b0;
   logic               rst       = 1'b1;
   logic               start     = 1'b0;
   logic               out_ready = 1'b1;
   logic [7:0]         rd_data   = 8'd0;
   logic               busy, done, rd_en, out_valid;
   logic [ADDR_W-1:0]  rd_addr;
   logic [OADDR_W-1:0] out_addr;
   logic [FRAC_W-1:0]  out_fx, out_fy;
   logic [7:0]         out_a1, out_a2, out_a3, out_a4;

   int checks     = 0;
   int failures   = 0;
   int cyc        = 0;
   int hs_total   = 0;
   int done_total = 0;
   int frame_pos  = 0;
   int rd_ptr     = 0;
   int rd_log[4]  = '{0, 0, 0, 0};
   logic [127:0] cap_bundle [NPIX];
   logic [127:0] cap_rd     [NPIX];

   typedef struct {
      int idx;
      int fx;
      int fy;
      int a1, a2, a3, a4;
      int r0, r1, r2, r3;
   } vec_t;
   vec_t vecs[7];

   downsample_ctrl #(
      .HIN(HIN), .HOUT(HOUT), .FRAC_W(FRAC_W), .STRIDE_Q(STRIDE_Q),
      .ADDR_W(ADDR_W), .OADDR_W(OADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_fx(out_fx), .out_fy(out_fy),
      .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3), .out_a4(out_a4)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter and ramp ifmap with one cycle of read latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en) rd_data <= rd_addr[7:0];
   end

   function automatic logic [127:0] packBundle(input int addr, input int fx, input int fy,
                                               input int a1, input int a2, input int a3, input int a4);
      return {16'd0, 16'(addr), 16'(fx), 16'(fy), 16'(a1), 16'(a2), 16'(a3), 16'(a4)};
   endfunction

   function automatic logic [127:0] packRd(input int n, input int r0, input int r1,
                                           input int r2, input int r3);
      return {48'd0, 16'(n), 16'(r0), 16'(r1), 16'(r2), 16'(r3)};
   endfunction

   function automatic logic [127:0] curBundle();
      return packBundle(int'(out_addr), int'(out_fx), int'(out_fy),
                        int'(out_a1), int'(out_a2), int'(out_a3), int'(out_a4));
   endfunction

   // Reference pixel from direct multiplication of the raster indices.
   function automatic void modelPixel(input int idx, output logic [127:0] bundle,
                                      output logic [127:0] rds);
      int i, j, py, px, fr, fc, cr, cc, fy, fx, a1, a2, a3, a4;
      i  = idx / HOUT;
      j  = idx % HOUT;
      py = i * STRIDE_Q;
      px = j * STRIDE_Q;
      fr = py / (1 << FRAC_W);
      fc = px / (1 << FRAC_W);
      fy = py % (1 << FRAC_W);
      fx = px % (1 << FRAC_W);
      cr = fr + ((fy != 0) ? 1 : 0);
      cc = fc + ((fx != 0) ? 1 : 0);
      if (cr > HIN - 1) cr = HIN - 1;
      if (cc > HIN - 1) cc = HIN - 1;
      a4 = fr * HIN + fc;
      a3 = fr * HIN + cc;
      a2 = cr * HIN + fc;
      a1 = cr * HIN + cc;
      bundle = packBundle(idx, fx, fy, a1 % 256, a2 % 256, a3 % 256, a4 % 256);
      rds    = packRd(4, a4, a3, a2, a1);
   endfunction

   // Handshake monitor: records each accepted bundle and the reads that fed it.
   always @(negedge clk) begin
      if (rst) begin
         frame_pos = 0;
         rd_ptr    = 0;
      end else begin
         if (rd_en) begin
            if (rd_ptr < 4) rd_log[rd_ptr] = int'(rd_addr);
            rd_ptr = rd_ptr + 1;
         end
         if (out_valid && out_ready) begin
            if (frame_pos < NPIX) begin
               cap_bundle[frame_pos] = curBundle();
               cap_rd[frame_pos]     = packRd(rd_ptr, rd_log[0], rd_log[1], rd_log[2], rd_log[3]);
            end
            frame_pos = frame_pos + 1;
            hs_total  = hs_total + 1;
            rd_ptr    = 0;
         end
         if (done) begin
            done_total = done_total + 1;
            frame_pos  = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   task automatic applyStimulus(input logic rst_v, input logic start_v, input logic ready_v);
      @(posedge clk);
      #1;
      rst       = rst_v;
      start     = start_v;
      out_ready = ready_v;
   endtask

   task automatic checkReset(input string name);
      checkOutput(name, 128'({busy, done, rd_en, out_valid, rd_addr, out_addr, out_fx, out_fy,
                              out_a1, out_a2, out_a3, out_a4}), 128'(0));
   endtask

   task automatic startFrame(input string tag, output int scyc);
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput({tag, "_busy_after_start"}, 128'(busy), 128'(1));
      scyc = cyc;
   endtask

   task automatic waitDone(input string tag, output int dcyc);
      bit   seen      = 1'b0;
      logic prev_busy = 1'b0;
      dcyc = 0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            dcyc = cyc;
            break;
         end
         prev_busy = busy;
      end
      checkOutput({tag, "_done_seen"}, 128'(seen), 128'(1));
      if (seen) begin
         checkOutput({tag, "_busy_at_done"}, 128'(busy), 128'(0));
         checkOutput({tag, "_busy_before_done"}, 128'(prev_busy), 128'(1));
      end
      @(negedge clk);
      checkOutput({tag, "_done_one_cycle"}, 128'(done), 128'(0));
   endtask

   task automatic checkFrame(input string tag, input int hs_base, input int done_base);
      logic [127:0] eb, er;
      checkOutput({tag, "_handshakes"}, 128'(hs_total - hs_base), 128'(NPIX));
      checkOutput({tag, "_done_pulses"}, 128'(done_total - done_base), 128'(1));
      for (int k = 0; k < NPIX; k++) begin
         modelPixel(k, eb, er);
         checkOutput($sformatf("%s_pix%0d_bundle", tag, k), cap_bundle[k], eb);
         checkOutput($sformatf("%s_pix%0d_reads", tag, k), cap_rd[k], er);
      end
   endtask

   // Main sequence: reset, nominal frame with a stray start, backpressure
   // frame, and a frame aborted by reset then restarted.
   initial begin
      int scyc, dcyc, hs_base, done_base;
      bit found;
      logic [127:0] snap;

      //            idx  fx   fy   a1   a2   a3   a4   r0   r1   r2   r3
      vecs[0] = '{  0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0};
      vecs[1] = '{  1, 114,   0,   2,   1,   2,   1,   1,   2,   1,   2};
      vecs[2] = '{ 21, 228, 114,  57,  56,  30,  29,  29,  30,  56,  57};
      vecs[3] = '{360,   4,   4, 216, 216, 216, 216, 728, 728, 728, 728};
      vecs[4] = '{ 18,   4,   0,  26,  26,  26,  26,  26,  26,  26,  26};
      vecs[5] = '{ 38,   0, 228,  81,  81,  54,  54,  54,  54,  81,  81};
      vecs[6] = '{ 62,  58,  86, 143, 142, 116, 115, 115, 116, 142, 143};

      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkReset("reset_init");
      applyStimulus(1'b0, 1'b0, 1'b1);

      hs_base   = hs_total;
      done_base = done_total;
      startFrame("f1", scyc);
      repeat (40) @(posedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitDone("f1", dcyc);
      checkOutput("f1_frame_cycles", 128'(dcyc - scyc + 1), 128'(6*NPIX + 1));
      checkFrame("f1", hs_base, done_base);
      for (int v = 0; v < 7; v++) begin
         checkOutput($sformatf("vec%0d_bundle", v), cap_bundle[vecs[v].idx],
                     packBundle(vecs[v].idx, vecs[v].fx, vecs[v].fy,
                                vecs[v].a1, vecs[v].a2, vecs[v].a3, vecs[v].a4));
         checkOutput($sformatf("vec%0d_reads", v), cap_rd[vecs[v].idx],
                     packRd(4, vecs[v].r0, vecs[v].r1, vecs[v].r2, vecs[v].r3));
      end
      repeat (5) @(negedge clk);
      checkOutput("idle_after_done", 128'({busy, done, rd_en, out_valid}), 128'(0));
      checkOutput("no_extra_done", 128'(done_total - done_base), 128'(1));

      hs_base   = hs_total;
      done_base = done_total;
      startFrame("f2", scyc);
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (out_valid && out_addr == 4) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("bp_reach_pixel4", 128'(found), 128'(1));
      applyStimulus(1'b0, 1'b0, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("bp_valid_seen", 128'(found), 128'(1));
      checkOutput("bp_stall_pixel", 128'(out_addr), 128'(5));
      snap = curBundle();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput($sformatf("bp_valid_c%0d", k), 128'(out_valid), 128'(1));
         checkOutput($sformatf("bp_rd_en_c%0d", k), 128'(rd_en), 128'(0));
         checkOutput($sformatf("bp_bundle_c%0d", k), curBundle(), snap);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitDone("f2", dcyc);
      checkFrame("f2", hs_base, done_base);

      done_base = done_total;
      startFrame("f3", scyc);
      repeat (100) @(posedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkReset("reset_mid");
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      checkOutput("abort_idle", 128'({busy, rd_en, out_valid}), 128'(0));
      checkOutput("abort_no_done", 128'(done_total - done_base), 128'(0));

      hs_base   = hs_total;
      done_base = done_total;
      startFrame("f3b", scyc);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("restart_valid_seen", 128'(found), 128'(1));
      checkOutput("restart_addr", 128'(out_addr), 128'(0));
      waitDone("f3b", dcyc);
      checkOutput("f3b_frame_cycles", 128'(dcyc - scyc + 1), 128'(6*NPIX + 1));
      checkFrame("f3b", hs_base, done_base);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
